// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bus levels and
// the default target address (also used by the controller bench).
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one I2C line: 2-flop synchroniser, glitch filter
// and one-clk edge flags of the filtered level.
//   clk, rst_n : system clock, async active-low reset
//   line_i     : raw pad level
//   level_o    : filtered level (1 after reset)
//   rise_o     : one-clk pulse, filtered level went 0 -> 1
//   fall_o     : one-clk pulse, filtered level went 1 -> 0
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, fall_q;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address; open-drain SDA via sda_oe, never
// touches SCL, no clock stretching.
//   clk, rst_n        : system clock, async active-low reset
//   scl_in, sda_in    : raw pad levels
//   sda_oe            : 1 = pull SDA low
//   busy, rd_mode     : matched transfer in progress / its R/W bit
//   rx_data/valid/first : received write byte, strobe, first-after-address
//   tx_req, tx_data   : read byte request pulse / byte supplied by host
//   stop_det          : pulse on every STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       rd_mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       stop_det
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rd_mode_q, rd_mode_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       stop_det_q, stop_det_d;
    logic       first_q, first_d;   // next write byte is the first since address
    logic       load_q, load_d;     // read byte must be fetched on next scl_fall

    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rd_mode_d  = rd_mode_q;
        first_d    = first_q;
        load_d     = load_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        stop_det_d = 1'b0;

        if (stop_cond) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
            load_d     = 1'b0;
        end else if (start_cond) begin
            state_d  = ST_ADDR;
            bitcnt_d = 3'd7;
            sda_oe_d = 1'b0;
            load_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        if (bitcnt_q == '0) begin
                            sda_oe_d = 1'b0;
                            if (shift_q[6:0] == TARGET_ADDR) begin
                                busy_d    = 1'b1;
                                rd_mode_d = sda_lvl;
                                tx_req_d  = sda_lvl;
                                first_d   = 1'b1;
                                state_d   = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    // sda_oe still low means this is the fall that opens the ACK slot.
                    if (scl_fall) begin
                        bitcnt_d = 3'd7;
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else if (state_q == ST_ADDR_ACK && rd_mode_q) begin
                            shift_d  = {tx_data[6:0], 1'b0};
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        if (bitcnt_q == '0) begin
                            rx_data_d  = {shift_q[6:0], sda_lvl};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            state_d    = ST_WR_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Shift register holds the bits still to send, MSB-aligned,
                    // so the bit being driven has already left it.
                    if (scl_fall) begin
                        if (load_q) begin
                            shift_d  = {tx_data[6:0], 1'b0};
                            sda_oe_d = ~tx_data[7];
                            bitcnt_d = 3'd7;
                            load_d   = 1'b0;
                        end else if (bitcnt_q != '0) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[7];
                            bitcnt_d = bitcnt_q - 3'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            tx_req_d = 1'b1;
                            load_d   = 1'b1;
                            state_d  = ST_RD_DATA;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_mode_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_det_q <= 1'b0;
            first_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rd_mode_q  <= rd_mode_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            stop_det_q <= stop_det_d;
            first_q    <= first_d;
            load_q     <= load_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign rd_mode  = rd_mode_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_q;
    assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int Q = 100;   // quarter SCL period: SCL = 40 clk

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       glitch = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       scl_in, sda_in;
    logic       sda_oe, busy, rd_mode, rx_valid, rx_first, tx_req, stop_det;
    logic [7:0] rx_data;

    // Open-drain bus: anyone pulling low wins.
    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe & ~glitch;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(ADDR), .FILTER_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .busy(busy), .rd_mode(rd_mode), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_first(rx_first), .tx_req(tx_req),
        .tx_data(tx_data), .stop_det(stop_det)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rx_q[$];
    logic       rxf_q[$];
    logic [7:0] tx_src[$];
    int         tx_req_cnt = 0;
    int         stop_cnt = 0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;

    // Bus-side observer and host responder for tx_req.
    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxf_q.push_back(rx_first);
        end
        if (tx_req) begin
            tx_req_cnt++;
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
            else tx_data = 8'hEE;
        end
        if (stop_det) stop_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clock_bit(input logic b, input logic g, output logic s);
        #Q m_sda = b;
        #Q m_scl = 1'b1;
        if (g) begin
            #(Q/2) glitch = 1'b1;
            #10 glitch = 1'b0;
            #(Q/2 - 10);
        end else begin
            #Q;
        end
        s = sda_in;
        #Q m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #(2*Q) m_sda = 1'b0;
        #(2*Q) m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b1;
        #(2*Q) m_sda = 1'b1;
        #(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == gbit), s);
        clock_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(nack, 1'b0, s);
    endtask

    initial begin
        logic       ack, s, match, rw;
        logic [7:0] d;
        logic [6:0] a;
        logic [7:0] data [3];
        int         len, s0, tx0;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe",   32'(sda_oe),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_rd_mode",  32'(rd_mode),  0);
        check("rst_rx_data",  32'(rx_data),  0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_first", 32'(rx_first), 0);
        check("rst_tx_req",   32'(tx_req),   0);
        check("rst_stop_det", 32'(stop_det), 0);
        @(negedge clk) rst_n = 1'b1;
        #(4*Q);

        // Write: 0x84, 0x10, 0xA5
        rx_q.delete(); rxf_q.delete(); s0 = stop_cnt; tx0 = tx_req_cnt;
        i2c_start();
        write_byte(8'h84, -1, ack); check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("wr_busy", 32'(busy), 1);
        check("wr_rd_mode", 32'(rd_mode), 0);
        write_byte(8'h10, -1, ack); check("wr_d0_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'hA5, -1, ack); check("wr_d1_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        check("wr_rx_count", 32'(rx_q.size()), 2);
        check("wr_rx0", 32'(rx_q[0]), 32'h10);
        check("wr_rx0_first", 32'(rxf_q[0]), 1);
        check("wr_rx1", 32'(rx_q[1]), 32'hA5);
        check("wr_rx1_first", 32'(rxf_q[1]), 0);
        check("wr_stop", 32'(stop_cnt - s0), 1);
        check("wr_busy_end", 32'(busy), 0);
        check("wr_no_txreq", 32'(tx_req_cnt - tx0), 0);

        // Read with repeated START
        rx_q.delete(); rxf_q.delete(); s0 = stop_cnt; tx0 = tx_req_cnt;
        tx_src.push_back(8'h3C); tx_src.push_back(8'h7E);
        i2c_start();
        write_byte(8'h84, -1, ack); check("rd_waddr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h00, -1, ack); check("rd_ptr_ack", 32'(ack), 32'(I2C_ACK));
        i2c_start();
        check("rd_busy_rs", 32'(busy), 1);
        write_byte(8'h85, -1, ack); check("rd_raddr_ack", 32'(ack), 32'(I2C_ACK));
        check("rd_rd_mode", 32'(rd_mode), 1);
        read_byte(I2C_ACK, d);  check("rd_byte0", 32'(d), 32'h3C);
        read_byte(I2C_NACK, d); check("rd_byte1", 32'(d), 32'h7E);
        #Q;
        check("rd_oe_after_nack", 32'(sda_oe), 0);
        check("rd_txreq_count", 32'(tx_req_cnt - tx0), 2);
        i2c_stop();
        check("rd_rx_count", 32'(rx_q.size()), 1);
        check("rd_rx_ptr", 32'(rx_q[0]), 32'h00);
        check("rd_stop", 32'(stop_cnt - s0), 1);
        check("rd_busy_end", 32'(busy), 0);

        // Address mismatch
        rx_q.delete(); rxf_q.delete(); s0 = stop_cnt;
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'h90, -1, ack); check("mm_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h55, -1, ack); check("mm_data_nack", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        check("mm_oe_never", 32'(oe_seen), 0);
        check("mm_busy_never", 32'(busy_seen), 0);
        check("mm_no_rx", 32'(rx_q.size()), 0);
        check("mm_stop", 32'(stop_cnt - s0), 1);

        // Glitches: idle and mid-byte
        rx_q.delete(); rxf_q.delete(); s0 = stop_cnt;
        @(negedge clk) glitch = 1'b1;
        @(negedge clk) glitch = 1'b0;
        #(3*Q);
        check("gl_idle_nostop", 32'(stop_cnt - s0), 0);
        i2c_start();
        write_byte(8'h84, -1, ack); check("gl_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'hA5, 7, ack);  check("gl_data_ack", 32'(ack), 32'(I2C_ACK));
        check("gl_mid_nostop", 32'(stop_cnt - s0), 0);
        i2c_stop();
        check("gl_rx_count", 32'(rx_q.size()), 1);
        check("gl_rx0", 32'(rx_q[0]), 32'hA5);
        check("gl_rx0_first", 32'(rxf_q[0]), 1);

        // Abort after 4 data bits
        rx_q.delete(); rxf_q.delete(); s0 = stop_cnt;
        i2c_start();
        write_byte(8'h84, -1, ack); check("ab_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 4; i++) clock_bit(i[0], 1'b0, s);
        i2c_stop();
        check("ab_no_rx", 32'(rx_q.size()), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_stop", 32'(stop_cnt - s0), 1);
        check("ab_oe", 32'(sda_oe), 0);

        // Asynchronous reset while ACKing
        i2c_start();
        d = 8'h84;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], 1'b0, s);
        #Q;
        check("ar_acking", 32'(sda_oe), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("ar_oe_async", 32'(sda_oe), 0);
        check("ar_busy_async", 32'(busy), 0);
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q;
        @(negedge clk) rst_n = 1'b1;
        #(4*Q);

        // Randomised transactions against a byte-level bus model
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 2) != 0) a = ADDR;
            else begin
                a = 7'($urandom);
                if (a == ADDR) a = ~a;
            end
            rw    = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 3);
            match = (a == ADDR);
            for (int i = 0; i < 3; i++) data[i] = 8'($urandom);
            rx_q.delete(); rxf_q.delete(); s0 = stop_cnt; tx0 = tx_req_cnt;
            oe_seen = 1'b0;
            if (rw && match) for (int i = 0; i < len; i++) tx_src.push_back(data[i]);
            i2c_start();
            write_byte({a, rw}, -1, ack);
            check("rnd_addr_ack", 32'(ack), match ? 32'(I2C_ACK) : 32'(I2C_NACK));
            for (int i = 0; i < len; i++) begin
                if (!rw) begin
                    write_byte(data[i], -1, ack);
                    check("rnd_wr_ack", 32'(ack), match ? 32'(I2C_ACK) : 32'(I2C_NACK));
                end else begin
                    read_byte((i == len - 1) ? I2C_NACK : I2C_ACK, d);
                    check("rnd_rd_byte", 32'(d), match ? 32'(data[i]) : 32'hFF);
                end
            end
            i2c_stop();
            check("rnd_rx_count", 32'(rx_q.size()), (!rw && match) ? 32'(len) : 0);
            for (int i = 0; i < len && i < rx_q.size(); i++) begin
                check("rnd_rx_byte", 32'(rx_q[i]), 32'(data[i]));
                check("rnd_rx_first", 32'(rxf_q[i]), (i == 0) ? 1 : 0);
            end
            check("rnd_txreq", 32'(tx_req_cnt - tx0), (rw && match) ? 32'(len) : 0);
            check("rnd_stop", 32'(stop_cnt - s0), 1);
            check("rnd_busy_end", 32'(busy), 0);
            if (!match) check("rnd_mm_oe", 32'(oe_seen), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
